// File: rtl/ring_flit_pkg.sv
// Shared definitions for the reply-flit ring protocol: flit geometry, ctrl tags and
// upload FSM encodings.
package ring_flit_pkg;

    localparam int FLIT_W    = 16;
    localparam int MAX_FLITS = 10;
    localparam int CNT_W     = 4;
    localparam int MSG_W     = FLIT_W * MAX_FLITS;

    typedef enum logic [1:0] {
        CTRL_NONE = 2'b00,
        CTRL_HEAD = 2'b01,
        CTRL_BODY = 2'b10,
        CTRL_TAIL = 2'b11
    } ctrl_e;

    typedef enum logic [1:0] {
        UP_IDLE = 2'b00,
        UP_BUSY = 2'b01
    } up_state_e;

    // Zero or an oversize request both mean "send the whole message".
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] n);
        if (n == '0 || n > CNT_W'(MAX_FLITS)) return CNT_W'(MAX_FLITS);
        return n;
    endfunction

endpackage

// File: rtl/m_rep_upload_if.sv
// Reply upload bus: message hand-off from the memory controller on one side,
// flit stream into the router's OUT_rep fifo on the other.
interface m_rep_upload_if;
    import ring_flit_pkg::*;

    logic [MSG_W-1:0]  m_flits_rep;
    logic              v_m_flits_rep;
    logic [CNT_W-1:0]  flits_max;
    logic              OUT_rep_rdy;
    logic [1:0]        m_rep_upload_state;
    logic              m_rep_upload_rdy;
    logic [FLIT_W-1:0] m_rep_flit;
    logic              v_m_rep_flit;
    logic [1:0]        m_rep_ctrl;

    modport slave (
        input  m_flits_rep, v_m_flits_rep, flits_max, OUT_rep_rdy,
        output m_rep_upload_state, m_rep_upload_rdy, m_rep_flit, v_m_rep_flit, m_rep_ctrl
    );

    modport master (
        output m_flits_rep, v_m_flits_rep, flits_max, OUT_rep_rdy,
        input  m_rep_upload_state, m_rep_upload_rdy, m_rep_flit, v_m_rep_flit, m_rep_ctrl
    );

endinterface

// File: rtl/rep_flit_sel.sv
// Combinational MAX_FLITS:1 mux picking the flit addressed by the counter out of the
// message buffer.
module rep_flit_sel
    import ring_flit_pkg::*;
(
    input  logic [MSG_W-1:0]  buf_i,
    input  logic [CNT_W-1:0]  sel_i,
    output logic [FLIT_W-1:0] flit_o
);

    // NOTE: give every combinational output a default before any branch so no latch is inferred.
    always_comb begin
        flit_o = '0;
        for (int i = 0; i < MAX_FLITS; i++) begin
            if (sel_i == CNT_W'(i)) flit_o = buf_i[i*FLIT_W +: FLIT_W];
        end
    end

endmodule

// File: rtl/m_rep_upload.sv
// Reply upload: latches a whole reply message in one beat and serialises it into
// head/body/tail-tagged flits towards the OUT_rep fifo.
module m_rep_upload
    import ring_flit_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    m_rep_upload_if.slave  up_if
);

    up_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [MSG_W-1:0]  buf_q, buf_d;
    logic [FLIT_W-1:0] sel_flit;
    logic              is_tail;

    assign is_tail = (cnt_q == len_q - CNT_W'(1));

    rep_flit_sel u_flit_sel (
        .buf_i  (buf_q),
        .sel_i  (cnt_q),
        .flit_o (sel_flit)
    );

    // NOTE: sequential state is updated with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= UP_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: the message buffer is a plain register bank, so it is reset and cleared after the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            len_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
            buf_q <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        buf_d   = buf_q;
        unique case (state_q)
            UP_IDLE: begin
                if (up_if.v_m_flits_rep) begin
                    buf_d   = up_if.m_flits_rep;
                    len_d   = clamp_len(up_if.flits_max);
                    cnt_d   = '0;
                    state_d = UP_BUSY;
                end
            end
            UP_BUSY: begin
                // A strobe arriving here, including the tail cycle, is dropped.
                if (up_if.OUT_rep_rdy) begin
                    if (is_tail) begin
                        state_d = UP_IDLE;
                        cnt_d   = '0;
                        buf_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = UP_IDLE;
        endcase
    end

    always_comb begin
        up_if.m_rep_upload_state = state_q;
        up_if.m_rep_upload_rdy   = (state_q == UP_IDLE);
        up_if.m_rep_flit         = '0;
        up_if.v_m_rep_flit       = 1'b0;
        up_if.m_rep_ctrl         = CTRL_NONE;
        if (state_q == UP_BUSY) begin
            up_if.m_rep_flit   = sel_flit;
            up_if.v_m_rep_flit = up_if.OUT_rep_rdy;
            if (is_tail)             up_if.m_rep_ctrl = CTRL_TAIL;
            else if (cnt_q == '0)    up_if.m_rep_ctrl = CTRL_HEAD;
            else                     up_if.m_rep_ctrl = CTRL_BODY;
        end
    end

endmodule
